// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard FSM: load-use stall, branch flush, data-memory wait (HAZARD_STALL_CNT_EN adds stall counter)
module hazard_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, LOAD_STALL, BRANCH_FLUSH, MEM_WAIT} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       pend, pend_nxt;
    logic       load_use;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
        pend_nxt  = 1'b0;
        if (dmem_req && !dmem_ready) begin
            // a branch resolving while memory holds the pipe is replayed on release
            state_nxt = MEM_WAIT;
            pend_nxt  = pend | mem_branch_taken;
        end else if (mem_branch_taken || (state == MEM_WAIT && pend)) begin
            state_nxt = BRANCH_FLUSH;
            cnt_nxt   = FLUSH_LOAD;
        end else if (state == BRANCH_FLUSH && cnt > 3'd1) begin
            state_nxt = BRANCH_FLUSH;
            cnt_nxt   = cnt - 3'd1;
        end else if (state == IDLE && load_use) begin
            state_nxt = LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state)
            LOAD_STALL: begin
                stall      = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                flush_idex = 1'b1;
            end
            BRANCH_FLUSH: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            MEM_WAIT: begin
                stall      = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_memread, mem_branch_taken, dmem_req, dmem_ready;
    logic        stall, pc_write, ifid_write, flush_ifid, flush_idex;
    logic [15:0] stall_cycles;

    hazard_unit #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall, pc_write, ifid_write, flush_ifid, flush_idex}
    localparam logic [4:0] O_IDLE = 5'b01100;
    localparam logic [4:0] O_LS   = 5'b10001;
    localparam logic [4:0] O_BF   = 5'b01111;
    localparam logic [4:0] O_MW   = 5'b10000;

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       uses_rt, memread;
        logic [4:0] rd;
        logic       br, req, rdy;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  exp;
        logic [15:0] exp_cnt;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [4:0]  prev_exp;
    logic [15:0] cnt_model;

    function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic ur, logic mr,
                                logic [4:0] rd, logic br, logic req, logic rdy, logic [4:0] e);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memread = mr;
        v.rd = rd; v.br = br; v.req = req; v.rdy = rdy; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp();
`ifdef HAZARD_STALL_CNT_EN
        return cnt_model;
`else
        return 16'd0;
`endif
    endfunction

    task automatic check_outs(input string name, input logic [4:0] e, input logic [15:0] ec);
        check({name, ".ctl"}, {11'd0, stall, pc_write, ifid_write, flush_ifid, flush_idex}, {11'd0, e});
        check({name, ".cnt"}, stall_cycles, ec);
    endtask

    task automatic step(input vec_t v);
        sb_t s;
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; ex_memread = v.memread;
        ex_rd = v.rd; mem_branch_taken = v.br; dmem_req = v.req; dmem_ready = v.rdy;
        if (prev_exp[4] && cnt_model != 16'hFFFF) cnt_model++;
        s.name = v.name; s.exp = v.exp; s.exp_cnt = cnt_exp();
        sb.push_back(s);
        prev_exp = v.exp;
        @(posedge clk);
        #1;
        s = sb.pop_front();
        check_outs(s.name, s.exp, s.exp_cnt);
    endtask

    task automatic async_reset(input string name);
        #1;
        reset = 1'b0;
        #1;
        check_outs(name, O_IDLE, 16'd0);
        prev_exp  = O_IDLE;
        cnt_model = 16'd0;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rd = 0;
        mem_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rd = 0;
        mem_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
        prev_exp  = O_IDLE;
        cnt_model = 16'd0;

        //                 name          rs  rt ur mr rd br rq rdy exp
        tbl.push_back(mk("idle",        0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("lu_rs",       5,  0, 0, 1, 5, 0, 0, 0, O_LS));
        tbl.push_back(mk("lu_rs_done",  0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("lu_rs_idle",  0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("rd_zero",     0,  0, 0, 1, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("rt_unused",   0,  7, 0, 1, 7, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("lu_rt",       0,  7, 1, 1, 7, 0, 0, 0, O_LS));
        tbl.push_back(mk("lu_hold",     0,  7, 1, 1, 7, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("lu_clear",    0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("no_load",     5,  0, 0, 0, 5, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("br1",         0,  0, 0, 0, 0, 1, 0, 0, O_BF));
        tbl.push_back(mk("br1_c2",      0,  0, 0, 0, 0, 0, 0, 0, O_BF));
        tbl.push_back(mk("br1_end",     0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("br2",         0,  0, 0, 0, 0, 1, 0, 0, O_BF));
        tbl.push_back(mk("br2_c2",      0,  0, 0, 0, 0, 0, 0, 0, O_BF));
        tbl.push_back(mk("br2_re",      0,  0, 0, 0, 0, 1, 0, 0, O_BF));
        tbl.push_back(mk("br2_re_c2",   0,  0, 0, 0, 0, 0, 0, 0, O_BF));
        tbl.push_back(mk("br2_end",     0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("zero_wait",   0,  0, 0, 0, 0, 0, 1, 1, O_IDLE));
        tbl.push_back(mk("mw_c1",       0,  0, 0, 0, 0, 0, 1, 0, O_MW));
        tbl.push_back(mk("mw_c2_br",    0,  0, 0, 0, 0, 1, 1, 0, O_MW));
        tbl.push_back(mk("mw_c3",       0,  0, 0, 0, 0, 0, 1, 0, O_MW));
        tbl.push_back(mk("mw_c4",       0,  0, 0, 0, 0, 0, 1, 0, O_MW));
        tbl.push_back(mk("mw_pend_f1",  0,  0, 0, 0, 0, 0, 0, 0, O_BF));
        tbl.push_back(mk("mw_pend_f2",  0,  0, 0, 0, 0, 0, 0, 0, O_BF));
        tbl.push_back(mk("mw_pend_end", 0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("mw_nb",       0,  0, 0, 0, 0, 0, 1, 0, O_MW));
        tbl.push_back(mk("mw_nb_rdy",   0,  0, 0, 0, 0, 0, 1, 1, O_IDLE));
        tbl.push_back(mk("pri_mw_lu",   3,  0, 0, 1, 3, 0, 1, 0, O_MW));
        tbl.push_back(mk("pri_mw_exit", 0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk("pri_br_lu",   3,  0, 0, 1, 3, 1, 0, 0, O_BF));
        tbl.push_back(mk("pri_br_c2",   0,  0, 0, 0, 0, 0, 0, 0, O_BF));
        tbl.push_back(mk("pri_br_end",  0,  0, 0, 0, 0, 0, 0, 0, O_IDLE));

        #12;
        check_outs("reset_state", O_IDLE, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // reset in MEM_WAIT with a branch pending: nothing may survive
        step(mk("rmw_c1", 0, 0, 0, 0, 0, 0, 1, 0, O_MW));
        step(mk("rmw_c2", 0, 0, 0, 0, 0, 1, 1, 0, O_MW));
        async_reset("rst_in_mw");
        step(mk("rmw_after", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
        step(mk("rmw_after2", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));

        // reset in BRANCH_FLUSH abandons the window
        step(mk("rbf_br", 0, 0, 0, 0, 0, 1, 0, 0, O_BF));
        async_reset("rst_in_bf");
        step(mk("rbf_after", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));

        // three-cycle MEM_WAIT from a fresh reset for the stall counter
        step(mk("cnt_mw1", 0, 0, 0, 0, 0, 0, 1, 0, O_MW));
        step(mk("cnt_mw2", 0, 0, 0, 0, 0, 0, 1, 0, O_MW));
        step(mk("cnt_mw3", 0, 0, 0, 0, 0, 0, 1, 0, O_MW));
        step(mk("cnt_done", 0, 0, 0, 0, 0, 0, 1, 1, O_IDLE));
`ifdef HAZARD_STALL_CNT_EN
        check("cnt_three", stall_cycles, 16'd3);
`else
        check("cnt_tied", stall_cycles, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles IF/ID and ID/EX are flushed after a taken branch (legal range 1..7).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port id_rs  input  5  source register 1 of the instruction in decode.
REQ-005 SHALL have port id_rt  input  5  source register 2 of the instruction in decode.
REQ-006 SHALL have port id_uses_rt  input  1  decode instruction reads id_rt (R-type, store, BEQ).
REQ-007 SHALL have port ex_memread  input  1  the instruction in EX is a load.
REQ-008 SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-009 SHALL have port mem_branch_taken  input  1  the branch in M resolved taken this cycle.
REQ-010 SHALL have port dmem_req  input  1  M stage has a data-memory access outstanding.
REQ-011 SHALL have port dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 SHALL have port stall  output  1  freezes decode; feeds the decode control unit stall input.
REQ-013 SHALL have port pc_write  output  1  PC update enable.
REQ-014 SHALL have port ifid_write  output  1  IF/ID register load enable.
REQ-015 SHALL have port flush_ifid  output  1  clears IF/ID to a bubble.
REQ-016 SHALL have port flush_idex  output  1  clears ID/EX to a bubble.
REQ-017 SHALL have port stall_cycles  output  16  count of cycles with stall=1.

Function
REQ-018 SHALL implement a registered FSM with the states IDLE, LOAD_STALL, BRANCH_FLUSH and MEM_WAIT; all outputs SHALL be Moore outputs decoded from the state register.
REQ-019 SHALL detect load-use when ex_memread=1, ex_rd!=0 and either ex_rd==id_rs or (id_uses_rt=1 and ex_rd==id_rt).
REQ-020 SHALL use the following next-state priority from any state: dmem_req & !dmem_ready -> MEM_WAIT; else mem_branch_taken -> BRANCH_FLUSH; else load-use (only from IDLE) -> LOAD_STALL; else IDLE.
REQ-021 SHALL hold LOAD_STALL for exactly one cycle, then return to IDLE: stall=1, pc_write=0, ifid_write=0, flush_idex=1, flush_ifid=0.
REQ-022 SHALL load a 3-bit counter with FLUSH_CYCLES on entry to BRANCH_FLUSH and decrement it each cycle; the FSM SHALL leave the state when the count reaches 1; outputs in this state: flush_ifid=1, flush_idex=1, stall=0, pc_write=1, ifid_write=1.
REQ-023 SHALL, on mem_branch_taken in BRANCH_FLUSH, reload the counter with FLUSH_CYCLES (the flush window restarts).
REQ-024 SHALL remain in MEM_WAIT until dmem_ready=1, with stall=1, pc_write=0, ifid_write=0 and no flushes.
REQ-025 SHALL, on mem_branch_taken during MEM_WAIT, set a pending-branch flag; on exit from MEM_WAIT with the flag set, the FSM SHALL go to BRANCH_FLUSH and clear the flag.
REQ-026 SHALL drive stall=0, pc_write=1, ifid_write=1 and no flushes in IDLE.
REQ-027 SHALL treat dmem_ready=1 on the same cycle as dmem_req as a zero-wait access: MEM_WAIT is not entered.

Reset
REQ-028 SHALL, while reset=0 (asynchronously), force state=IDLE, counter=0, pending flag=0, stall_cycles=0; outputs SHALL then be stall=0, pc_write=1, ifid_write=1, flush_ifid=0, flush_idex=0.
REQ-029 SHALL let reset asserted mid-MEM_WAIT or mid-BRANCH_FLUSH abandon the operation with no pending state surviving.

Configuration
REQ-030 SHALL, with HAZARD_STALL_CNT_EN defined, increment stall_cycles each cycle stall=1 and saturate it at 16'hFFFF.
REQ-031 SHALL, without HAZARD_STALL_CNT_EN, keep the stall_cycles port and tie it to 0, with no counter logic.

Verification
REQ-032 SHALL cover: ex_memread=1, ex_rd=5, id_rs=5 for one cycle -> next cycle stall=1, pc_write=0, flush_idex=1 for exactly one cycle, then IDLE.
REQ-033 SHALL cover: ex_memread=1, ex_rd=0, id_rs=0 -> no stall; and ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-034 SHALL cover: mem_branch_taken pulse with FLUSH_CYCLES=2 -> flush_ifid=flush_idex=1 for exactly 2 cycles; a second pulse in the 2nd cycle -> 2 more cycles.
REQ-035 SHALL cover: dmem_req=1, dmem_ready=0 for 4 cycles with a branch pulse in cycle 2 -> stall=1 for 4 cycles, then 2 flush cycles.
REQ-036 SHALL cover: reset=0 asserted during MEM_WAIT -> outputs reach their reset values immediately without a clock edge; with HAZARD_STALL_CNT_EN, stall_cycles=0 after reset and 3 after a 3-cycle MEM_WAIT.
